pusch_mod_mapper: RTL and testbench

PUSCH_MOD_MAPPER -- requirements
Module: pusch_mod_mapper

---
 rtl/pusch_mod_pkg.sv | 40 ++++
 rtl/pusch_qam_lut.sv | 50 +++++
 rtl/pusch_mod_mapper.sv | 119 +++++++++++
 tb/tb_pusch_mod_mapper.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pusch_mod_pkg.sv
// Shared constants, modulation codes and FSM state type for the PUSCH modulation mapper.
// Optional macro PUSCH_PI2_BPSK_EN enables pi/2-BPSK on mod_order code 4.
package pusch_mod_pkg;

  localparam int DATA_WIDTH = 18;
  localparam int MAX_SC     = 1200;

  localparam logic [2:0] MOD_QPSK    = 3'd0;
  localparam logic [2:0] MOD_16QAM   = 3'd1;
  localparam logic [2:0] MOD_64QAM   = 3'd2;
  localparam logic [2:0] MOD_256QAM  = 3'd3;
  localparam logic [2:0] MOD_PI2BPSK = 3'd4;

  localparam int AMP_QPSK   = 91;
  localparam int AMP_16QAM  = 40;
  localparam int AMP_64QAM  = 20;
  localparam int AMP_256QAM = 10;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    EMIT,
    DONE,
    SWITCH
  } state_t;

  // Unsupported codes fall back to QPSK's two bits per symbol.
  function automatic logic [3:0] bits_per_sym(input logic [2:0] ord);
    case (ord)
      MOD_16QAM:   return 4'd4;
      MOD_64QAM:   return 4'd6;
      MOD_256QAM:  return 4'd8;
`ifdef PUSCH_PI2_BPSK_EN
      MOD_PI2BPSK: return 4'd1;
`endif
      default:     return 4'd2;
    endcase
  endfunction

endpackage

// File: rtl/pusch_qam_lut.sv
// Combinational bit-group to {I,Q} constellation mapper (b0 in bits[0]).
// Optional macro PUSCH_PI2_BPSK_EN enables pi/2-BPSK on mod_order code 4.
module pusch_qam_lut #(
  parameter int DATA_WIDTH = 18
) (
  input  logic [7:0]            bits,
  input  logic [2:0]            order,
  input  logic                  idx_odd,
  output logic [DATA_WIDTH-1:0] iq
);
  import pusch_mod_pkg::*;

  localparam int HALF = DATA_WIDTH / 2;

  logic signed [HALF-1:0] i_lvl;
  logic signed [HALF-1:0] q_lvl;

  function automatic int sgn(input logic b);
    return b ? -1 : 1;
  endfunction

  // b[0] is the sign bit of the axis, b[3:1] refine the amplitude.
  function automatic logic signed [HALF-1:0] level(input logic [2:0] ord, input logic [3:0] b);
    case (ord)
      MOD_16QAM:  return HALF'(sgn(b[0]) * (2 - sgn(b[1])) * AMP_16QAM);
      MOD_64QAM:  return HALF'(sgn(b[0]) * (4 - sgn(b[1]) * (2 - sgn(b[2]))) * AMP_64QAM);
      MOD_256QAM: return HALF'(sgn(b[0]) * (8 - sgn(b[1]) * (4 - sgn(b[2]) * (2 - sgn(b[3])))) * AMP_256QAM);
      default:    return HALF'(sgn(b[0]) * AMP_QPSK);
    endcase
  endfunction

  always_comb begin
    i_lvl = level(order, {bits[6], bits[4], bits[2], bits[0]});
    q_lvl = level(order, {bits[7], bits[5], bits[3], bits[1]});
`ifdef PUSCH_PI2_BPSK_EN
    if (order == MOD_PI2BPSK) begin
      q_lvl = HALF'(sgn(bits[0]) * AMP_QPSK);
      i_lvl = idx_odd ? -q_lvl : q_lvl;
    end
`endif
  end

  assign iq = {i_lvl, q_lvl};

`ifndef PUSCH_PI2_BPSK_EN
  logic unused_idx;
  assign unused_idx = idx_odd;
`endif

endmodule

// File: rtl/pusch_mod_mapper.sv
// PUSCH modulation mapper: collects scrambled bits, emits one mapped symbol per group.
// Optional macro PUSCH_PI2_BPSK_EN enables pi/2-BPSK on mod_order code 4.
module pusch_mod_mapper #(
  parameter int DATA_WIDTH = 18,
  parameter int MAX_SC     = 1200
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  sym_start,
  input  logic [2:0]            mod_order,
  input  logic [10:0]           num_sc,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  output logic                  bit_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  write_enable,
  output logic                  Mod_Valid_OUT,
  output logic [10:0]           write_addr,
  output logic [10:0]           Last_addr,
  output logic                  MOD_DONE,
  output logic                  PINGPONG_SWITCH
);
  import pusch_mod_pkg::*;

  localparam logic [10:0] MAX_SC_W = 11'(MAX_SC);

  state_t                state;
  logic [2:0]            order_r;
  logic [10:0]           nsc_r;
  logic [10:0]           sym_cnt;
  logic [2:0]            bit_cnt;
  logic [7:0]            bits;
  logic [7:0]            grp;
  logic [3:0]            qm;
  logic [DATA_WIDTH-1:0] lut_iq;

  assign qm            = bits_per_sym(order_r);
  assign bit_ready     = (state == COLLECT);
  assign Mod_Valid_OUT = write_enable;

  // The incoming bit is merged so the final bit of a group maps in the cycle it arrives.
  always_comb begin
    grp          = bits;
    grp[bit_cnt] = bit_in;
  end

  pusch_qam_lut #(.DATA_WIDTH(DATA_WIDTH)) u_lut (
    .bits    (grp),
    .order   (order_r),
    .idx_odd (sym_cnt[0]),
    .iq      (lut_iq)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state           <= IDLE;
      order_r         <= '0;
      nsc_r           <= '0;
      sym_cnt         <= '0;
      bit_cnt         <= '0;
      bits            <= '0;
      data_out        <= '0;
      write_enable    <= 1'b0;
      write_addr      <= '0;
      Last_addr       <= '0;
      MOD_DONE        <= 1'b0;
      PINGPONG_SWITCH <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sym_start && (num_sc != '0) && (num_sc <= MAX_SC_W)) begin
            order_r <= mod_order;
            nsc_r   <= num_sc;
            sym_cnt <= '0;
            bit_cnt <= '0;
            state   <= COLLECT;
          end
        end
        COLLECT: begin
          if (bit_valid) begin
            bits <= grp;
            if ({1'b0, bit_cnt} == qm - 4'd1) begin
              bit_cnt      <= '0;
              data_out     <= lut_iq;
              write_enable <= 1'b1;
              write_addr   <= sym_cnt + 11'd1;
              sym_cnt      <= sym_cnt + 11'd1;
              state        <= EMIT;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        EMIT: begin
          write_enable <= 1'b0;
          data_out     <= '0;
          if (sym_cnt < nsc_r) begin
            state <= COLLECT;
          end else begin
            MOD_DONE  <= 1'b1;
            Last_addr <= nsc_r;
            state     <= DONE;
          end
        end
        DONE: begin
          MOD_DONE        <= 1'b0;
          PINGPONG_SWITCH <= 1'b1;
          state           <= SWITCH;
        end
        SWITCH: begin
          PINGPONG_SWITCH <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pusch_mod_mapper.sv
// Scoreboard bench for pusch_mod_mapper with an arithmetic constellation reference model.
// Honours PUSCH_PI2_BPSK_EN the same way as the design build.
module tb_pusch_mod_mapper;

  logic        CLK = 1'b0;
  logic        RST;
  logic        sym_start;
  logic [2:0]  mod_order;
  logic [10:0] num_sc;
  logic        bit_in;
  logic        bit_valid;
  logic        bit_ready;
  logic [17:0] data_out;
  logic        write_enable;
  logic        Mod_Valid_OUT;
  logic [10:0] write_addr;
  logic [10:0] Last_addr;
  logic        MOD_DONE;
  logic        PINGPONG_SWITCH;

  pusch_mod_mapper #(.DATA_WIDTH(18), .MAX_SC(1200)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .sym_start       (sym_start),
    .mod_order       (mod_order),
    .num_sc          (num_sc),
    .bit_in          (bit_in),
    .bit_valid       (bit_valid),
    .bit_ready       (bit_ready),
    .data_out        (data_out),
    .write_enable    (write_enable),
    .Mod_Valid_OUT   (Mod_Valid_OUT),
    .write_addr      (write_addr),
    .Last_addr       (Last_addr),
    .MOD_DONE        (MOD_DONE),
    .PINGPONG_SWITCH (PINGPONG_SWITCH)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [17:0] data;
    int          addr;
  } exp_t;

  exp_t expq[$];
  int   doneq[$];
  int   preq[$];
  int   total = 0;
  int   bad = 0;
  int   sw_count = 0;
  int   exp_last = 0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int sgn(input logic b);
    return b ? -1 : 1;
  endfunction

  function automatic int qm_of(input int ord);
`ifdef PUSCH_PI2_BPSK_EN
    if (ord == 4) return 1;
`endif
    case (ord)
      1: return 4;
      2: return 6;
      3: return 8;
      default: return 2;
    endcase
  endfunction

  // Amplitude built from the innermost refinement bit outwards, then scaled.
  function automatic logic [17:0] ref_sym(input int ord, input logic [7:0] g, input int idx);
    int m, scale, vi, vq, iv, qv;
`ifdef PUSCH_PI2_BPSK_EN
    if (ord == 4) begin
      qv = sgn(g[0]) * 91;
      iv = (idx % 2 == 1) ? -qv : qv;
      return {9'(iv), 9'(qv)};
    end
`endif
    case (ord)
      1: begin m = 2; scale = 40; end
      2: begin m = 3; scale = 20; end
      3: begin m = 4; scale = 10; end
      default: begin m = 1; scale = 91; end
    endcase
    vi = 1;
    vq = 1;
    for (int k = m - 1; k >= 1; k--) begin
      vi = (1 << (m - k)) - sgn(g[2*k]) * vi;
      vq = (1 << (m - k)) - sgn(g[2*k+1]) * vq;
    end
    iv = sgn(g[0]) * vi * scale;
    qv = sgn(g[1]) * vq * scale;
    return {9'(iv), 9'(qv)};
  endfunction

  // Monitor: pops expectations whenever the DUT presents something.
  always @(negedge CLK) begin
    if (RST) begin
      if (write_enable) begin
        if (expq.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          check("data_out", int'(data_out), int'(e.data));
          check("write_addr", int'(write_addr), e.addr);
          check("mod_valid", int'(Mod_Valid_OUT), 1);
        end
      end else begin
        check("idle_zero", int'({data_out, Mod_Valid_OUT}), 0);
      end
      if (MOD_DONE) begin
        if (doneq.size() == 0) check("unexpected_done", 1, 0);
        else exp_last = doneq.pop_front();
      end
      check("last_addr", int'(Last_addr), exp_last);
      if (PINGPONG_SWITCH) begin
        check("switch_after_done", int'(prev_done), 1);
        sw_count++;
      end
      prev_done = MOD_DONE;
    end
  end

  task automatic start_sym(input int ord, input int nsc);
    mod_order = 3'(ord);
    num_sc    = 11'(nsc);
    sym_start = 1'b1;
    @(posedge CLK); #1;
    sym_start = 1'b0;
  endtask

  // gap: 0 none, 1 one idle cycle before each bit, 2 random 0..2 idle cycles.
  task automatic send_bit(input logic b, input int gap);
    int n, c;
    n = (gap == 1) ? 1 : (gap == 2) ? $urandom_range(0, 2) : 0;
    repeat (n) begin @(posedge CLK); #1; end
    bit_in    = b;
    bit_valid = 1'b1;
    for (c = 0; c < 50; c++) begin
      @(negedge CLK);
      if (bit_ready) break;
    end
    if (c == 50) check("bit_ready_timeout", 0, 1);
    @(posedge CLK); #1;
    bit_valid = 1'b0;
  endtask

  task automatic do_symbol(input int ord, input int nsc, input int gap, input bit inject);
    int          base, c;
    logic [7:0]  g;
    logic        b;
    base = sw_count;
    start_sym(ord, nsc);
    for (int s = 0; s < nsc; s++) begin
      g = '0;
      for (int k = 0; k < qm_of(ord); k++) begin
        b = (preq.size() > 0) ? 1'(preq.pop_front()) : 1'($urandom_range(0, 1));
        g[k] = b;
        send_bit(b, gap);
        if (inject && s == 0 && k == 0) start_sym(3, 5);
      end
      expq.push_back('{data: ref_sym(ord, g, s), addr: s + 1});
    end
    doneq.push_back(nsc);
    for (c = 0; c < 50 && sw_count == base; c++) @(negedge CLK);
    check("switch_seen", int'(sw_count != base), 1);
    @(posedge CLK); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b0; sym_start = 1'b0; mod_order = '0; num_sc = '0;
    bit_in = 1'b0; bit_valid = 1'b0;
    repeat (3) @(posedge CLK); #1;
    check("rst_outputs", int'({data_out, write_enable, Mod_Valid_OUT, MOD_DONE, PINGPONG_SWITCH, bit_ready}), 0);
    check("rst_addr", int'({write_addr, Last_addr}), 0);
    RST = 1'b1;
    @(posedge CLK); #1;

    preq = '{0, 0, 0, 1, 1, 1};
    do_symbol(0, 3, 0, 1'b0);
    preq = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    do_symbol(3, 2, 0, 1'b0);
    do_symbol(1, 4, 1, 1'b0);

    start_sym(0, 0);
    repeat (3) @(negedge CLK);
    check("nsc0_ready", int'(bit_ready), 0);
    @(posedge CLK); #1;
    start_sym(0, 1201);
    repeat (3) @(negedge CLK);
    check("nsc1201_ready", int'(bit_ready), 0);
    @(posedge CLK); #1;

    do_symbol(0, 2, 0, 1'b1);

    start_sym(2, 2);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    #2;
    RST = 1'b0;
    exp_last = 0;
    #1;
    check("midrst_outputs", int'({data_out, write_enable, Mod_Valid_OUT, MOD_DONE, PINGPONG_SWITCH, bit_ready}), 0);
    check("midrst_addr", int'({write_addr, Last_addr}), 0);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    do_symbol(2, 2, 0, 1'b0);

    preq = '{0, 0, 0, 0};
    do_symbol(4, 2, 0, 1'b0);

    for (int t = 0; t < 10; t++)
      do_symbol($urandom_range(0, 4), $urandom_range(1, 6), 2, 1'b0);

    do_symbol(0, 1, 0, 1'b0);
    do_symbol(0, 1200, 0, 1'b0);

    repeat (4) @(posedge CLK);
    check("expq_drained", expq.size(), 0);
    check("doneq_drained", doneq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
